// File: rtl/aes_ostream_pkg.sv
// Shared AES streaming types: state-array geometry and the word type used by
// block/word converters on both the input and output side of the cipher.
// No ports; imported by aes_oblock_buf and aes_ostream.
package aes_ostream_pkg;

   // Number of 32-bit columns in the AES state.
   localparam int Nb = 4;

   // State bytes, index 4*c+r (column c, row r), same order as cipher Data_out.
   typedef logic [7:0] aes_block_t [0:4*Nb-1];

   // One state column packed big-endian: byte 4c at [31:24].
   typedef logic [31:0] aes_word_t;

endpackage

// File: rtl/aes_oblock_buf.sv
// Block storage for the AES output streamer: DEPTH whole state blocks.
// Ports: clk_i; write port wr_en_i/wr_slot_i/wr_blk_i (whole block per cycle);
//        read port rd_slot_i/rd_word_i -> rd_dat_o (combinational column read).
module aes_oblock_buf
   import aes_ostream_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int WW = $clog2(Nb)
) (
   input  logic          clk_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_slot_i,
   input  aes_block_t    wr_blk_i,
   input  logic [AW-1:0] rd_slot_i,
   input  logic [WW-1:0] rd_word_i,
   output aes_word_t     rd_dat_o
);

   // Storage is deliberately not reset; the top masks the output when empty.
   logic [7:0] mem_q [0:DEPTH-1][0:4*Nb-1];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         for (int b = 0; b < 4*Nb; b++) begin
            mem_q[wr_slot_i][b] <= wr_blk_i[b];
         end
      end
   end

   // Byte index of row r in column w is {w, r}.
   logic [WW+1:0] idx;

   always_comb begin
      rd_dat_o = '0;
      idx      = '0;
      for (int r = 0; r < 4; r++) begin
         idx = {rd_word_i, 2'(r)};
         rd_dat_o[31-8*r -: 8] = mem_q[rd_slot_i][idx];
      end
   end

endmodule

// File: rtl/aes_ostream.sv
// AES output streamer: captures finished cipher blocks into a block FIFO and
// emits each as Nb 32-bit words over valid/ready, with a Last marker.
// Ports: clk/rst; Data_in/Ready_in (block capture), Busy_out (full);
//        Word_out/Valid_out/Word_ready/Last_out (word stream); Overflow_out (sticky drop flag).
module aes_ostream
   import aes_ostream_pkg::*;
#(
   parameter int DEPTH = 2    // power of two, >= 2
) (
   input  logic        clk,
   input  logic        rst,
   input  aes_block_t  Data_in,
   input  logic        Ready_in,
   output logic        Busy_out,
   output logic [31:0] Word_out,
   output logic        Valid_out,
   input  logic        Word_ready,
   output logic        Last_out,
   output logic        Overflow_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int WW = $clog2(Nb);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [WW-1:0] WC_LAST  = WW'(Nb-1);

   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WW-1:0] wc_q, wc_d;
   logic          ovf_q, ovf_d;

   logic      xfer, pop_last, push, drop;
   aes_word_t rd_word;

   assign xfer     = Valid_out && Word_ready;
   assign pop_last = xfer && (wc_q == WC_LAST);
   // A slot freed by the last-word pop this cycle can be refilled at once,
   // so a full buffer still accepts a block coincident with that pop.
   assign push     = Ready_in && ((cnt_q < CNT_FULL) || pop_last);
   assign drop     = Ready_in && (cnt_q == CNT_FULL) && !pop_last;

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      wc_d  = wc_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q | drop;
      if (push) begin
         wp_d = wp_q + 1'b1;
      end
      if (xfer) begin
         if (pop_last) begin
            wc_d = '0;
            rp_d = rp_q + 1'b1;
         end else begin
            wc_d = wc_q + 1'b1;
         end
      end
      if (push && !pop_last) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop_last && !push) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         wc_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         wc_q  <= wc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   aes_oblock_buf #(.DEPTH(DEPTH)) u_buf (
      .clk_i     (clk),
      .wr_en_i   (push),
      .wr_slot_i (wp_q),
      .wr_blk_i  (Data_in),
      .rd_slot_i (rp_q),
      .rd_word_i (wc_q),
      .rd_dat_o  (rd_word)
   );

   assign Valid_out    = (cnt_q != '0);
   assign Busy_out     = (cnt_q == CNT_FULL);
   assign Last_out     = Valid_out && (wc_q == WC_LAST);
   // Storage is unreset; mask so Word_out reads 0 whenever nothing is queued.
   assign Word_out     = Valid_out ? rd_word : 32'h0;
   assign Overflow_out = ovf_q;

endmodule

// File: tb/tb_aes_ostream.sv
// Directed bench for aes_ostream (DEPTH=2): reset, single block, backpressure,
// back-to-back, overflow, push-on-full-pop and mid-stream reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled in that window.
module tb_aes_ostream;
   import aes_ostream_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data_in [0:4*Nb-1];
   logic        Ready_in;
   logic        Busy_out;
   logic [31:0] Word_out;
   logic        Valid_out;
   logic        Word_ready;
   logic        Last_out;
   logic        Overflow_out;

   aes_ostream #(.DEPTH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .Data_in      (data_in),
      .Ready_in     (Ready_in),
      .Busy_out     (Busy_out),
      .Word_out     (Word_out),
      .Valid_out    (Valid_out),
      .Word_ready   (Word_ready),
      .Last_out     (Last_out),
      .Overflow_out (Overflow_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0]  got_w [$];
   logic         got_l [$];
   logic [127:0] exp_q [$];

   // FIPS-197 C.1 ciphertext plus two simple byte ramps.
   logic [127:0] blk_a = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   logic [127:0] blk_b = 128'h000102030405060708090a0b0c0d0e0f;
   logic [127:0] blk_c = 128'h101112131415161718191a1b1c1d1e1f;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [127:0] b);
      for (int i = 0; i < 4*Nb; i++) data_in[i] = b[127-8*i -: 8];
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, {31'b0, Valid_out},    32'd0);
      check({tag, "_last"},  {31'b0, Last_out},     32'd0);
      check({tag, "_busy"},  {31'b0, Busy_out},     32'd0);
      check({tag, "_ovf"},   {31'b0, Overflow_out}, 32'd0);
      check({tag, "_word"},  Word_out,              32'd0);
   endtask

   // Collect words until Valid_out drops. mode 1 drives Word_ready 1,0,0,1,0,0...
   // inject: pulse Ready_in with inj_blk in the first cycle showing Last with Busy.
   task automatic drain(input int mode, input int maxc, input logic inject, input logic [127:0] inj_blk);
      int          k;
      logic        done, pend, stall;
      logic [31:0] pw;
      logic        pl;
      k = 0; done = 1'b0; pend = inject; stall = 1'b0; pw = '0; pl = 1'b0;
      while (!done) begin
         Word_ready = (mode == 1) ? (k % 3 == 0) : 1'b1;
         Ready_in   = 1'b0;
         if (pend && Last_out && Busy_out) begin
            load(inj_blk);
            Ready_in = 1'b1;
            pend     = 1'b0;
         end
         if (!Valid_out) begin
            done = 1'b1;
         end else begin
            if (stall) begin
               check("hold_word", Word_out, pw);
               check("hold_last", {31'b0, Last_out}, {31'b0, pl});
            end
            if (Word_ready) begin
               got_w.push_back(Word_out);
               got_l.push_back(Last_out);
               stall = 1'b0;
            end else begin
               stall = 1'b1;
               pw    = Word_out;
               pl    = Last_out;
            end
         end
         if (!done) begin
            step();
            k++;
            if (k > maxc) begin
               check("drain_timeout", 32'd1, 32'd0);
               done = 1'b1;
            end
         end
      end
      Ready_in = 1'b0;
   endtask

   task automatic check_stream(input string tag);
      logic [127:0] b;
      check({tag, "_nwords"}, 32'(got_w.size()), 32'(4*exp_q.size()));
      for (int i = 0; i < got_w.size() && i < 4*exp_q.size(); i++) begin
         b = exp_q[i/4];
         check({tag, "_word"}, got_w[i], b[127-32*(i%4) -: 32]);
         check({tag, "_last"}, {31'b0, got_l[i]}, {31'b0, (i % 4 == 3)});
      end
      got_w.delete();
      got_l.delete();
      exp_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] b;
      rst = 1'b1; Ready_in = 1'b0; Word_ready = 1'b0; load('0);
      step(); step();
      rst = 1'b0;
      check_idle("reset");

      // Single block: words in the 4 cycles after the pulse, then idle.
      Word_ready = 1'b1;
      load(blk_a); Ready_in = 1'b1;
      step();
      Ready_in = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("single_valid", {31'b0, Valid_out}, 32'd1);
         check("single_word", Word_out, blk_a[127-32*c -: 32]);
         check("single_last", {31'b0, Last_out}, {31'b0, (c == 3)});
         step();
      end
      check("single_end_valid", {31'b0, Valid_out}, 32'd0);

      // Backpressure with Word_ready 1,0,0,1,...
      Word_ready = 1'b0;
      load(blk_a); Ready_in = 1'b1;
      step();
      Ready_in = 1'b0;
      exp_q.push_back(blk_a);
      drain(1, 40, 1'b0, '0);
      check_stream("bp");

      // Back-to-back: second pulse in the same cycle as block A's last word.
      Word_ready = 1'b1;
      load(blk_a); Ready_in = 1'b1;
      step();
      for (int cyc = 1; cyc <= 8; cyc++) begin
         if (cyc == 4) begin
            load(blk_b); Ready_in = 1'b1;
         end else begin
            Ready_in = 1'b0;
         end
         b = (cyc <= 4) ? blk_a : blk_b;
         check("b2b_valid", {31'b0, Valid_out}, 32'd1);
         check("b2b_word", Word_out, b[127-32*((cyc-1)%4) -: 32]);
         check("b2b_last", {31'b0, Last_out}, {31'b0, (cyc == 4 || cyc == 8)});
         step();
      end
      Ready_in = 1'b0;
      check("b2b_end_valid", {31'b0, Valid_out}, 32'd0);

      // Overflow: third block dropped, only A and B come out.
      Word_ready = 1'b0;
      load(blk_a); Ready_in = 1'b1;
      step();
      load(blk_b);
      step();
      check("ovf_busy2", {31'b0, Busy_out}, 32'd1);
      check("ovf_pre", {31'b0, Overflow_out}, 32'd0);
      load(blk_c);
      step();
      Ready_in = 1'b0;
      check("ovf_set", {31'b0, Overflow_out}, 32'd1);
      check("ovf_busy3", {31'b0, Busy_out}, 32'd1);
      exp_q.push_back(blk_a);
      exp_q.push_back(blk_b);
      drain(0, 40, 1'b0, '0);
      check_stream("ovf");
      check("ovf_sticky", {31'b0, Overflow_out}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("ovf_cleared", {31'b0, Overflow_out}, 32'd0);

      // Push coincident with last-word pop while full.
      Word_ready = 1'b0;
      load(blk_a); Ready_in = 1'b1;
      step();
      load(blk_b);
      step();
      Ready_in = 1'b0;
      check("fullpop_busy", {31'b0, Busy_out}, 32'd1);
      exp_q.push_back(blk_a);
      exp_q.push_back(blk_b);
      exp_q.push_back(blk_c);
      drain(0, 60, 1'b1, blk_c);
      check_stream("fullpop");
      check("fullpop_ovf", {31'b0, Overflow_out}, 32'd0);

      // Reset after two words of a block.
      Word_ready = 1'b1;
      load(blk_a); Ready_in = 1'b1;
      step();
      Ready_in = 1'b0;
      check("rst_w0", Word_out, blk_a[127:96]);
      step();
      check("rst_w1", Word_out, blk_a[95:64]);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_idle("rst_mid");
      step();
      check("rst_quiet", {31'b0, Valid_out}, 32'd0);
      load(blk_b); Ready_in = 1'b1;
      step();
      Ready_in = 1'b0;
      exp_q.push_back(blk_b);
      drain(0, 20, 1'b0, '0);
      check_stream("rst_new");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
